// File: rtl/cpu_pkg.sv
// Shared LEGv8 core definitions: datapath widths, fetch FSM states and
// the sign-extender control codes used by decode.
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 64;

    localparam logic [ADDR_W-1:0] PC_INC     = 64'd4;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~64'h3;

    typedef enum logic {
        FETCH,
        HOLD
    } fetch_state_t;

    typedef enum logic [2:0] {
        EXT_I,
        EXT_D,
        EXT_B,
        EXT_CBZ,
        EXT_MOVZ
    } ext_ctrl_t;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC adder: sequential step or word-scaled branch offset, always
// word-aligned, modulo 2^64.
module next_pc_calc
    import cpu_pkg::*;
(
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] bus_imm,
    input  logic              br_taken,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] sum;

    // The offset is in words, so the shift discards the two top bits.
    assign offset  = br_taken ? (bus_imm << 2) : PC_INC;
    assign sum     = pc + offset;
    assign next_pc = sum & ALIGN_MASK;

endmodule

// File: rtl/fetch_pc_unit.sv
// LEGv8 fetch stage: owns the PC, fetches over a req/ack memory handshake
// and hands each instruction to decode over valid/ready.
module fetch_pc_unit
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h0,
    parameter int                CNT_W    = 32
) (
    input  logic               CLK,
    input  logic               Reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               InstrValid,
    input  logic               InstrReady,
    output logic [INSTR_W-1:0] Instr,
    output logic [ADDR_W-1:0]  InstrPC,
    input  logic               BrTaken,
    input  logic [ADDR_W-1:0]  BusImm,
    output logic [CNT_W-1:0]   FetchCount
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] next_pc;

    next_pc_calc u_next_pc (
        .pc       (InstrPC),
        .bus_imm  (BusImm),
        .br_taken (BrTaken),
        .next_pc  (next_pc)
    );

    // Reset gates the handshake outputs immediately so memory never sees
    // a request in the cycle Reset is asserted.
    assign imem_req   = (state == FETCH) && !Reset;
    assign InstrValid = (state == HOLD) && !Reset;
    assign imem_addr  = pc;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state      <= FETCH;
            pc         <= RESET_PC & ALIGN_MASK;
            Instr      <= '0;
            InstrPC    <= '0;
            FetchCount <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        Instr   <= imem_rdata;
                        InstrPC <= pc;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (InstrReady) begin
                        pc         <= next_pc;
                        FetchCount <= FetchCount + CNT_W'(1);
                        state      <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule
